frame_crc_check: RTL and testbench

Modbus RTU request validator that sits directly downstream of `frame_rx` in the slave receive path. On each `rx_message_done` it captures the decoded request fields and recomputes CRC-16/MODBUS over the six request bytes. The six bytes are slave address, function code, address hi/lo and data hi/lo. It then compares the result with the received CRC and forwards the fields with a valid/error verdict to the command executor. Bit-serial CRC engine: one CRC bit per clock, no lookup table.

---
 rtl/frame_crc_check.sv | 171 +++++++++++++++++
 tb/tb_frame_crc_check.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_crc_check.sv
// rtl/frame_crc_check.sv - Modbus RTU request CRC-16 validator, bit-serial engine
module frame_crc_check #(
  parameter logic [7:0] ADDR = 8'h02
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        rx_message_done,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [15:0] crc_rx_code,
  output logic        busy,
  output logic        check_done,
  output logic        crc_ok,
  output logic        frame_valid,
  output logic [7:0]  func_code_o,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic [15:0] crc_calc,
  output logic [7:0]  crc_err_cnt,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_XOR, S_SHIFT, S_CMP} state_t;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  func_q, func_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] crc_rx_q, crc_rx_d;
  logic [15:0] crc_calc_q, crc_calc_d;
  logic        crc_ok_q, crc_ok_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        check_done_q, check_done_d;
  logic        frame_valid_q, frame_valid_d;
  logic        overrun_q, overrun_d;

  logic [7:0]  cur_byte;
  logic [15:0] crc_wire;
  logic        crc_match;

  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      3'd0:    cur_byte = ADDR;
      3'd1:    cur_byte = func_q;
      3'd2:    cur_byte = addr_q[15:8];
      3'd3:    cur_byte = addr_q[7:0];
      3'd4:    cur_byte = data_q[15:8];
      3'd5:    cur_byte = data_q[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  // The CRC is transmitted low byte first, so compare in wire order.
  assign crc_wire  = {crc_q[7:0], crc_q[15:8]};
  assign crc_match = (crc_wire == crc_rx_q);

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    byte_idx_d    = byte_idx_q;
    bit_cnt_d     = bit_cnt_q;
    func_d        = func_q;
    addr_d        = addr_q;
    data_d        = data_q;
    crc_rx_d      = crc_rx_q;
    crc_calc_d    = crc_calc_q;
    crc_ok_d      = crc_ok_q;
    err_cnt_d     = err_cnt_q;
    check_done_d  = 1'b0;
    frame_valid_d = 1'b0;
    overrun_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_message_done) begin
          func_d     = func_code;
          addr_d     = addr;
          data_d     = data;
          crc_rx_d   = crc_rx_code;
          crc_d      = 16'hFFFF;
          byte_idx_d = 3'd0;
          bit_cnt_d  = 3'd0;
          state_d    = S_XOR;
        end
      end
      S_XOR: begin
        crc_d   = crc_q ^ {8'h00, cur_byte};
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        crc_d     = crc_q[0] ? ((crc_q >> 1) ^ 16'hA001) : (crc_q >> 1);
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_idx_q == 3'd5) begin
            state_d = S_CMP;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = S_XOR;
          end
        end
      end
      S_CMP: begin
        crc_ok_d      = crc_match;
        crc_calc_d    = crc_wire;
        check_done_d  = 1'b1;
        frame_valid_d = crc_match;
        if (!crc_match && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving during CMP still counts as busy.
    if (rx_message_done && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      crc_q         <= 16'hFFFF;
      byte_idx_q    <= 3'd0;
      bit_cnt_q     <= 3'd0;
      func_q        <= 8'h00;
      addr_q        <= 16'h0000;
      data_q        <= 16'h0000;
      crc_rx_q      <= 16'h0000;
      crc_calc_q    <= 16'h0000;
      crc_ok_q      <= 1'b0;
      err_cnt_q     <= 8'h00;
      check_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      byte_idx_q    <= byte_idx_d;
      bit_cnt_q     <= bit_cnt_d;
      func_q        <= func_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      crc_rx_q      <= crc_rx_d;
      crc_calc_q    <= crc_calc_d;
      crc_ok_q      <= crc_ok_d;
      err_cnt_q     <= err_cnt_d;
      check_done_q  <= check_done_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign check_done  = check_done_q;
  assign crc_ok      = crc_ok_q;
  assign frame_valid = frame_valid_q;
  assign func_code_o = func_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign crc_calc    = crc_calc_q;
  assign crc_err_cnt = err_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_crc_check.sv
// tb/tb_frame_crc_check.sv - self-checking bench for frame_crc_check
module tb_frame_crc_check;

  localparam logic [7:0] SLV = 8'h01;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        rx_message_done;
  logic [7:0]  func_code;
  logic [15:0] addr;
  logic [15:0] data;
  logic [15:0] crc_rx_code;
  logic        busy, check_done, crc_ok, frame_valid, overrun;
  logic [7:0]  func_code_o, crc_err_cnt;
  logic [15:0] addr_o, data_o, crc_calc;

  int chk = 0;
  int bad = 0;

  frame_crc_check #(.ADDR(SLV)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .rx_message_done(rx_message_done),
    .func_code(func_code), .addr(addr), .data(data), .crc_rx_code(crc_rx_code),
    .busy(busy), .check_done(check_done), .crc_ok(crc_ok), .frame_valid(frame_valid),
    .func_code_o(func_code_o), .addr_o(addr_o), .data_o(data_o), .crc_calc(crc_calc),
    .crc_err_cnt(crc_err_cnt), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference CRC-16/MODBUS of the six request bytes, returned in wire order.
  function automatic logic [15:0] wire_crc(input logic [7:0] f, input logic [15:0] a,
                                           input logic [15:0] d);
    logic [7:0]  b [6];
    logic [15:0] c;
    b[0] = SLV; b[1] = f; b[2] = a[15:8]; b[3] = a[7:0]; b[4] = d[15:8]; b[5] = d[7:0];
    c = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      c = c ^ {8'h00, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return {c[7:0], c[15:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a check occupies 55 cycles after capture, verdict lands on the 56th.
  int          m_cnt;
  logic        m_done, m_ok, m_ovr, m_pend_ok;
  logic [15:0] m_calc, m_pend_calc, m_addr, m_data;
  logic [7:0]  m_err, m_func;

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_ok <= 1'b0; m_ovr <= 1'b0; m_pend_ok <= 1'b0;
      m_calc <= 16'h0; m_pend_calc <= 16'h0; m_addr <= 16'h0; m_data <= 16'h0;
      m_err <= 8'h0; m_func <= 8'h0;
    end else begin
      m_done <= 1'b0;
      m_ovr  <= 1'b0;
      if (m_cnt == 0) begin
        if (rx_message_done) begin
          m_cnt       <= 1;
          m_func      <= func_code;
          m_addr      <= addr;
          m_data      <= data;
          m_pend_calc <= wire_crc(func_code, addr, data);
          m_pend_ok   <= (wire_crc(func_code, addr, data) == crc_rx_code);
        end
      end else begin
        if (rx_message_done) m_ovr <= 1'b1;
        if (m_cnt == 55) begin
          m_cnt  <= 0;
          m_done <= 1'b1;
          m_ok   <= m_pend_ok;
          m_calc <= m_pend_calc;
          if (!m_pend_ok && m_err != 8'hFF) m_err <= m_err + 8'd1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (reset_n) begin
      check("busy", busy, m_cnt != 0);
      check("check_done", check_done, m_done);
      check("frame_valid", frame_valid, m_done & m_ok);
      check("overrun", overrun, m_ovr);
      check("crc_ok", crc_ok, m_ok);
      check("crc_calc", crc_calc, m_calc);
      check("crc_err_cnt", crc_err_cnt, m_err);
      check("func_code_o", func_code_o, m_func);
      check("addr_o", addr_o, m_addr);
      check("data_o", data_o, m_data);
    end
  end

  task automatic start_now(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] c);
    func_code = f; addr = a; data = d; crc_rx_code = c;
    rx_message_done = 1'b1;
    @(posedge sys_clk); #1;
    rx_message_done = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] c);
    @(posedge sys_clk); #1;
    start_now(f, a, d, c);
  endtask

  // Returns the cycle number (relative to capture) in which check_done is seen, or -1.
  task automatic wait_done(input int from, output int lat);
    lat = -1;
    for (int n = from; n <= from + 100; n++) begin
      @(negedge sys_clk);
      if (check_done) begin
        lat = n;
        break;
      end
      @(posedge sys_clk); #1;
    end
  endtask

  int lat;

  initial begin
    reset_n = 1'b0; rx_message_done = 1'b0;
    func_code = 8'h0; addr = 16'h0; data = 16'h0; crc_rx_code = 16'h0;
    #3;
    check("rst busy", busy, 1'b0);
    check("rst crc_calc", crc_calc, 16'h0000);
    check("rst err_cnt", crc_err_cnt, 8'h00);
    check("rst func_code_o", func_code_o, 8'h00);
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;

    start_frame(8'h03, 16'h0000, 16'h0001, 16'h840A);
    wait_done(1, lat);
    check("t1 latency", lat, 56);
    check("t1 crc_ok", crc_ok, 1'b1);
    check("t1 frame_valid", frame_valid, 1'b1);
    check("t1 crc_calc", crc_calc, 16'h840A);
    check("t1 err_cnt", crc_err_cnt, 8'h00);
    check("t1 busy", busy, 1'b0);

    start_frame(8'h03, 16'h0000, 16'h000A, 16'hC5CD);
    wait_done(1, lat);
    check("t2 latency", lat, 56);
    check("t2 crc_ok", crc_ok, 1'b1);
    check("t2 crc_calc", crc_calc, 16'hC5CD);

    start_frame(8'h03, 16'h0000, 16'h0001, 16'h0A84);
    wait_done(1, lat);
    check("t3 frame_valid", frame_valid, 1'b0);
    check("t3 crc_ok", crc_ok, 1'b0);
    check("t3 crc_calc", crc_calc, 16'h840A);
    check("t3 err_cnt", crc_err_cnt, 8'h01);

    start_frame(8'h03, 16'h0000, 16'h0001, 16'h840A);
    repeat (19) @(posedge sys_clk);
    #1;
    start_now(8'h55, 16'h1234, 16'h5678, 16'h0000);
    check("ovr pulse", overrun, 1'b1);
    @(posedge sys_clk); #1;
    check("ovr single", overrun, 1'b0);
    wait_done(22, lat);
    check("ovr latency", lat, 56);
    check("ovr crc_ok", crc_ok, 1'b1);
    check("ovr func_code_o", func_code_o, 8'h03);
    check("ovr err_cnt", crc_err_cnt, 8'h01);

    start_frame(8'h06, 16'h0010, 16'h00FF, 16'hBEEF);
    repeat (29) @(posedge sys_clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid rst busy", busy, 1'b0);
    check("mid rst func_code_o", func_code_o, 8'h00);
    check("mid rst crc_calc", crc_calc, 16'h0000);
    check("mid rst crc_ok", crc_ok, 1'b0);
    check("mid rst err_cnt", crc_err_cnt, 8'h00);
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge sys_clk);
      check("no done after rst", check_done, 1'b0);
    end
    start_frame(8'h03, 16'h0000, 16'h0001, 16'h840A);
    wait_done(1, lat);
    check("post rst latency", lat, 56);
    check("post rst frame_valid", frame_valid, 1'b1);

    // Back-to-back bad frames, each issued in the first cycle the checker is free.
    for (int i = 0; i < 256; i++) begin
      start_now(8'h04, 16'h0100, 16'(i), wire_crc(8'h04, 16'h0100, 16'(i)) ^ 16'h0101);
      wait_done(1, lat);
      check("sat latency", lat, 56);
    end
    check("sat err_cnt", crc_err_cnt, 8'hFF);
    start_now(8'h03, 16'h0000, 16'h0001, 16'h840A);
    wait_done(1, lat);
    check("sat good latency", lat, 56);
    check("sat good frame_valid", frame_valid, 1'b1);
    check("sat good err_cnt", crc_err_cnt, 8'hFF);

    repeat (3) @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", chk, bad);
    $finish;
  end

endmodule
